// File: rtl/fp_multi_multiplier.sv
// fp_multi_multiplier: IEEE-754 binary32 product of N_OPS operands on one iterative
// multiply/normalise/round datapath, with a fixed latency of 3*(N_OPS-1)+1 edges to z_ack.
module fp_multi_multiplier #(
   parameter int N_OPS = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [32*N_OPS-1:0]  operands,
   output logic [31:0]          output_z,
   output logic                 z_ack,
   output logic                 busy,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 invalid
);
   localparam int IW = $clog2(N_OPS + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_OPS);

   typedef enum logic [2:0] {IDLE, MULT, NORM, RND, PACK} state_t;
   typedef enum logic [1:0] {K_NUM, K_ZERO, K_INF, K_NAN} kind_t;

   state_t state_q, state_d;
   kind_t  acc_kind, scan_kind;

   logic [32*(N_OPS-1)-1:0] ops_q;
   logic [IW-1:0]           idx_q;
   logic                    acc_sign;
   logic signed [9:0]       acc_exp, step_exp, rnd_exp;
   logic [23:0]             acc_man, kept_q, rnd_man;
   logic [47:0]             prod_q;
   logic                    guard_q, round_q, sticky_q, rnd_up;
   logic [24:0]             rnd_sum;
   logic                    ovf_q, unf_q;
   logic [31:0]             pack_z;

   // Per-operand classification; denormals count as zero.
   logic [N_OPS-1:0] op_nan, op_inf, op_zero, op_sign;
   for (genvar g = 0; g < N_OPS; g++) begin : g_scan
      logic [7:0]  e;
      logic [22:0] f;
      assign e          = operands[32*g+23 +: 8];
      assign f          = operands[32*g +: 23];
      assign op_nan[g]  = (e == 8'hFF) && (f != '0);
      assign op_inf[g]  = (e == 8'hFF) && (f == '0);
      assign op_zero[g] = (e == 8'h00);
      assign op_sign[g] = operands[32*g+31];
   end

   always_comb begin
      scan_kind = K_NUM;
      if ((|op_nan) || ((|op_inf) && (|op_zero))) scan_kind = K_NAN;
      else if (|op_zero)                          scan_kind = K_ZERO;
      else if (|op_inf)                           scan_kind = K_INF;
   end

   always_comb begin
      rnd_up  = guard_q & (round_q | sticky_q | kept_q[0]);
      rnd_sum = {1'b0, kept_q} + 25'(rnd_up);
      rnd_man = rnd_sum[23:0];
      rnd_exp = step_exp;
      if (rnd_sum[24]) begin
         rnd_man = rnd_sum[24:1];
         rnd_exp = step_exp + 10'sd1;
      end
   end

   always_comb begin
      pack_z = {acc_sign, acc_exp[7:0], acc_man[22:0]};
      case (acc_kind)
         K_NAN:  pack_z = 32'h7FC0_0000;
         K_INF:  pack_z = {acc_sign, 8'hFF, 23'd0};
         K_ZERO: pack_z = {acc_sign, 31'd0};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = MULT;
         MULT: state_d = NORM;
         NORM: state_d = RND;
         RND:  state_d = ((idx_q + IW'(1)) == LAST_IDX) ? PACK : MULT;
         PACK: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         ops_q     <= '0;
         idx_q     <= '0;
         acc_sign  <= 1'b0;
         acc_kind  <= K_NUM;
         acc_exp   <= '0;
         acc_man   <= '0;
         step_exp  <= '0;
         prod_q    <= '0;
         kept_q    <= '0;
         guard_q   <= 1'b0;
         round_q   <= 1'b0;
         sticky_q  <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         output_z  <= '0;
         z_ack     <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         invalid   <= 1'b0;
      end else begin
         z_ack <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               ops_q    <= operands[32*N_OPS-1:32];
               acc_sign <= ^op_sign;
               acc_kind <= scan_kind;
               acc_exp  <= $signed({2'b00, operands[30:23]});
               acc_man  <= {1'b1, operands[22:0]};
               idx_q    <= IW'(1);
               ovf_q    <= 1'b0;
               unf_q    <= 1'b0;
            end
            MULT: begin
               prod_q   <= 48'(acc_man) * 48'({1'b1, ops_q[22:0]});
               step_exp <= acc_exp + $signed({2'b00, ops_q[30:23]}) - 10'sd127;
            end
            NORM: begin
               if (prod_q[47]) begin
                  kept_q   <= prod_q[47:24];
                  guard_q  <= prod_q[23];
                  round_q  <= prod_q[22];
                  sticky_q <= |prod_q[21:0];
                  step_exp <= step_exp + 10'sd1;
               end else begin
                  kept_q   <= prod_q[46:23];
                  guard_q  <= prod_q[22];
                  round_q  <= prod_q[21];
                  sticky_q <= |prod_q[20:0];
               end
            end
            RND: begin
               // Special accumulators (zero/inf/NaN) are frozen; only finite values advance.
               if (acc_kind == K_NUM) begin
                  if (rnd_exp > 10'sd254) begin
                     acc_kind <= K_INF;
                     ovf_q    <= 1'b1;
                  end else if (rnd_exp < 10'sd1) begin
                     acc_kind <= K_ZERO;
                     unf_q    <= 1'b1;
                  end else begin
                     acc_exp <= rnd_exp;
                     acc_man <= rnd_man;
                  end
               end
               ops_q <= ops_q >> 32;
               idx_q <= idx_q + IW'(1);
            end
            PACK: begin
               output_z  <= pack_z;
               overflow  <= ovf_q;
               underflow <= unf_q;
               invalid   <= (acc_kind == K_NAN);
               z_ack     <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_multi_multiplier.sv
// Bench for fp_multi_multiplier: N_OPS=3, 2 and 8 instances, expected results queued
// at issue and compared (value, flags, latency, busy) when each z_ack arrives.
module tb_fp_multi_multiplier;
   typedef struct {
      logic [31:0] z;
      logic [2:0]  fl;   // {overflow, underflow, invalid}
      int          at;
   } exp_t;

   logic         sys_clk_tb = 1'b0;
   logic         reset;
   logic         start3, start2, start8;
   logic [95:0]  ops3;
   logic [63:0]  ops2;
   logic [255:0] ops8;
   logic [31:0]  z3, z2, z8;
   logic         ack3, ack2, ack8, busy3, busy2, busy8;
   logic         ovf3, unf3, inv3, ovf2, unf2, inv2, ovf8, unf8, inv8;
   logic         prev3, prev2, prev8;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t q3[$], q2[$], q8[$];

   always #5 sys_clk_tb = ~sys_clk_tb;
   always @(posedge sys_clk_tb) cyc <= cyc + 1;

   fp_multi_multiplier #(.N_OPS(3)) dut3 (
      .clk(sys_clk_tb), .reset(reset), .start(start3), .operands(ops3), .output_z(z3),
      .z_ack(ack3), .busy(busy3), .overflow(ovf3), .underflow(unf3), .invalid(inv3));
   fp_multi_multiplier #(.N_OPS(2)) dut2 (
      .clk(sys_clk_tb), .reset(reset), .start(start2), .operands(ops2), .output_z(z2),
      .z_ack(ack2), .busy(busy2), .overflow(ovf2), .underflow(unf2), .invalid(inv2));
   fp_multi_multiplier #(.N_OPS(8)) dut8 (
      .clk(sys_clk_tb), .reset(reset), .start(start8), .operands(ops8), .output_z(z8),
      .z_ack(ack8), .busy(busy8), .overflow(ovf8), .underflow(unf8), .invalid(inv8));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic compare(input string tag, input exp_t e, input logic [31:0] z,
                          input logic [2:0] fl, input logic bsy);
      check({tag, "_z"}, z, e.z);
      check({tag, "_flags"}, 32'(fl), 32'(e.fl));
      check({tag, "_latency"}, cyc, e.at);
      check({tag, "_busy"}, 32'(bsy), 32'd0);
   endtask

   // Called at a negedge; the following posedge is the accept edge.
   task automatic issue(input int n, input logic [255:0] ops, input logic [31:0] z,
                        input logic [2:0] fl);
      exp_t e;
      e.z  = z;
      e.fl = fl;
      e.at = cyc + 1 + 3 * (n - 1) + 1;
      case (n)
         2:       begin start2 = 1'b1; ops2 = ops[63:0];  q2.push_back(e); end
         8:       begin start8 = 1'b1; ops8 = ops;        q8.push_back(e); end
         default: begin start3 = 1'b1; ops3 = ops[95:0];  q3.push_back(e); end
      endcase
      @(negedge sys_clk_tb);
      start2 = 1'b0;
      start3 = 1'b0;
      start8 = 1'b0;
      case (n)
         2:       check("busy_after_accept2", 32'(busy2), 32'd1);
         8:       check("busy_after_accept8", 32'(busy8), 32'd1);
         default: check("busy_after_accept3", 32'(busy3), 32'd1);
      endcase
   endtask

   task automatic drain();
      int n = 0;
      while ((q3.size() + q2.size() + q8.size()) != 0 && n < 60) begin
         @(negedge sys_clk_tb);
         n++;
      end
      check("drain_pending", 32'(q3.size() + q2.size() + q8.size()), 32'd0);
      @(negedge sys_clk_tb);
   endtask

   always @(negedge sys_clk_tb) begin
      if (prev3) check("ack_width3", 32'(ack3), 32'd0);
      if (ack3) begin
         check("ack_expected3", 32'(q3.size() > 0), 32'd1);
         if (q3.size() > 0) compare("n3", q3.pop_front(), z3, {ovf3, unf3, inv3}, busy3);
      end
      prev3 <= ack3;
   end

   always @(negedge sys_clk_tb) begin
      if (prev2) check("ack_width2", 32'(ack2), 32'd0);
      if (ack2) begin
         check("ack_expected2", 32'(q2.size() > 0), 32'd1);
         if (q2.size() > 0) compare("n2", q2.pop_front(), z2, {ovf2, unf2, inv2}, busy2);
      end
      prev2 <= ack2;
   end

   always @(negedge sys_clk_tb) begin
      if (prev8) check("ack_width8", 32'(ack8), 32'd0);
      if (ack8) begin
         check("ack_expected8", 32'(q8.size() > 0), 32'd1);
         if (q8.size() > 0) compare("n8", q8.pop_front(), z8, {ovf8, unf8, inv8}, busy8);
      end
      prev8 <= ack8;
   end

   localparam logic [95:0] OPS_A = {32'hBF800000, 32'h40200000, 32'hBF000000};
   localparam logic [95:0] OPS_B = {32'h3F800000, 32'h3F800001, 32'h3F800001};

   initial begin
      reset  = 1'b0;
      start3 = 1'b0;
      start2 = 1'b0;
      start8 = 1'b0;
      ops3   = '0;
      ops2   = '0;
      ops8   = '0;
      repeat (3) @(negedge sys_clk_tb);
      check("rst_z", z3, 32'd0);
      check("rst_ack", 32'(ack3), 32'd0);
      check("rst_busy", 32'(busy3), 32'd0);
      check("rst_flags", 32'({ovf3, unf3, inv3}), 32'd0);
      reset = 1'b1;
      @(negedge sys_clk_tb);

      // Directed values for N_OPS=3
      issue(3, 256'(OPS_A), 32'h3FA00000, 3'b000);
      drain();
      issue(3, 256'(OPS_B), 32'h3F800002, 3'b000);
      drain();
      issue(3, 256'({32'h3F800000, 32'h3FC00000, 32'h3F800001}), 32'h3FC00002, 3'b000);
      drain();
      issue(3, 256'({32'h3F800000, 32'h3FC00000, 32'h3FC00000}), 32'h40100000, 3'b000);
      drain();
      issue(3, 256'({32'h3F800000, 32'h40000000, 32'h7F000000}), 32'h7F800000, 3'b100);
      drain();
      issue(3, 256'({32'h3F800000, 32'h0D800000, 32'h8D800000}), 32'h80000000, 3'b010);
      drain();
      issue(3, 256'({32'h3F800000, 32'h00000000, 32'h7F800000}), 32'h7FC00000, 3'b001);
      drain();
      issue(3, 256'({32'h40000000, 32'h3F800000, 32'h80000001}), 32'h80000000, 3'b000);
      drain();

      // Other operand counts
      issue(2, 256'({32'h40200000, 32'hBF000000}), 32'hBFA00000, 3'b000);
      issue(8, {{5{32'h3F800000}}, OPS_A}, 32'h3FA00000, 3'b000);
      drain();

      // start while busy is ignored, operands free to change after accept
      issue(3, 256'(OPS_A), 32'h3FA00000, 3'b000);
      @(negedge sys_clk_tb);
      start3 = 1'b1;
      ops3   = OPS_B;
      @(negedge sys_clk_tb);
      start3 = 1'b0;
      drain();

      // start held through z_ack: second transaction accepted in the z_ack cycle
      begin
         exp_t e;
         int   n;
         e.z  = 32'h3FA00000;
         e.fl = 3'b000;
         e.at = cyc + 1 + 7;
         q3.push_back(e);
         start3 = 1'b1;
         ops3   = OPS_A;
         @(negedge sys_clk_tb);
         ops3 = OPS_B;
         n    = 0;
         while (!ack3 && n < 20) begin
            @(negedge sys_clk_tb);
            n++;
         end
         check("b2b_first_ack", 32'(ack3), 32'd1);
         e.z  = 32'h3F800002;
         e.at = cyc + 1 + 7;
         q3.push_back(e);
         @(negedge sys_clk_tb);
         start3 = 1'b0;
         check("b2b_busy", 32'(busy3), 32'd1);
         drain();
      end

      // Reset mid-transaction discards it
      issue(3, 256'(OPS_A), 32'h3FA00000, 3'b000);
      repeat (2) @(negedge sys_clk_tb);
      reset = 1'b0;
      q3.delete();
      @(negedge sys_clk_tb);
      check("midrst_busy", 32'(busy3), 32'd0);
      check("midrst_z", z3, 32'd0);
      check("midrst_flags", 32'({ovf3, unf3, inv3}), 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge sys_clk_tb);
         check("midrst_no_ack", 32'(ack3), 32'd0);
      end
      issue(3, 256'({32'h3F800000, 32'h40000000, 32'h7F000000}), 32'h7F800000, 3'b100);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
